// File: rtl/jtriders_pkg.sv
// Shared definitions for the Trick or Treat / Riders bus arbiter: state
// encoding and the default tenure and grant-delay limits.
package jtriders_pkg;

  localparam int MAXBURST_DEF = 64;
  localparam int GNTDLY_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SYNC = 3'd2,
    ST_OWN  = 3'd3,
    ST_REL  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/jtriders_rrsel.sv
// Two-input round-robin selector: a lone request wins outright, a tie goes
// to the master that was not granted last time.
module jtriders_rrsel (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       sel
);

  always_comb begin
    sel = 1'b0;
    case (req)
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_gnt;
      default: sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/jtriders_busarb.sv
// Arbitrates the 68000 bus between the protection DMA (bit0) and the object
// DMA (bit1) using the BR/BG/BGACK protocol; one DMA tenure per request cycle.
module jtriders_busarb
  import jtriders_pkg::*;
#(
  parameter int MAXBURST = MAXBURST_DEF,
  parameter int GNTDLY   = GNTDLY_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_cen,
  input  logic       ASn,
  input  logic       BGn,
  input  logic       bus_busy,
  input  logic [1:0] req,
  input  logic [1:0] strobe,
  input  logic [1:0] last,
  output logic       BRn,
  output logic       BGACKn,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       preempt,
  output arb_state_t dbg_state,
  output logic [7:0] dbg_burst
);

  // Master handshake: strobe is a one-clk "bus cycle done" pulse; last is
  // only meaningful on a strobe clk and marks the final cycle of the transfer.
  arb_state_t state;
  logic       win;
  logic       last_gnt;
  logic [7:0] burst;
  logic [3:0] held;

  logic own_stb, own_last, own_req, quiet, burst_max;

  assign own_stb   = strobe[owner];
  assign own_last  = last[owner];
  assign own_req   = req[owner];
  assign quiet     = ASn & ~bus_busy;
  assign burst_max = (burst == 8'(MAXBURST - 1));

  assign dbg_state = state;
  assign dbg_burst = burst;

  jtriders_rrsel u_rrsel (
    .req      (req),
    .last_gnt (last_gnt),
    .sel      (win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      BRn      <= 1'b1;
      BGACKn   <= 1'b1;
      gnt      <= 2'b00;
      owner    <= 1'b0;
      preempt  <= 1'b0;
      burst    <= 8'd0;
      held     <= 4'd0;
      last_gnt <= 1'b1;
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            owner <= win;
            BRn   <= 1'b0;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!own_req) begin
            BRn   <= 1'b1;
            state <= ST_IDLE;
          end else if (!BGn) begin
            held  <= 4'd0;
            state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          // The CPU must have left the bus for GNTDLY consecutive cpu_cen ticks.
          if (!quiet) begin
            held <= 4'd0;
          end else if (held == 4'(GNTDLY)) begin
            BRn    <= 1'b1;
            BGACKn <= 1'b0;
            gnt    <= owner ? 2'b10 : 2'b01;
            state  <= ST_OWN;
          end else if (cpu_cen) begin
            held <= held + 4'd1;
          end
        end
        ST_OWN: begin
          if (own_stb) burst <= burst + 8'd1;
          if ((own_stb && own_last) || !own_req || (own_stb && burst_max)) begin
            gnt     <= 2'b00;
            BGACKn  <= 1'b1;
            preempt <= own_stb && !own_last && own_req && burst_max;
            state   <= ST_REL;
          end
        end
        ST_REL: begin
          burst    <= 8'd0;
          last_gnt <= owner;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jtriders_busarb.md
JTRIDERS_BUSARB -- requirements
Module: jtriders_busarb

Interface
REQ-001 Parameter MAXBURST, default 64: maximum bus cycles per DMA tenure, range 2..255.
REQ-002 Parameter GNTDLY, default 2: cpu_cen ticks between ASn release and BGACKn assertion, range 1..15.
REQ-003 clk  in  1  system clock, 48 MHz; all logic is on the rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 cpu_cen  in  1  68000 clock enable.
REQ-006 ASn  in  1  68000 address strobe.
REQ-007 BGn  in  1  68000 bus grant.
REQ-008 bus_busy  in  1  SDRAM access still pending.
REQ-009 req  in  2  DMA requests: bit0 is the protection DMA, bit1 is the object DMA.
REQ-010 strobe  in  2  per-master bus-cycle-done pulse, one clk wide.
REQ-011 last  in  2  per-master end-of-transfer flag, sampled together with strobe.
REQ-012 BRn  out  1  68000 bus request.
REQ-013 BGACKn  out  1  68000 bus-grant acknowledge; it drives the main_addr mux select.
REQ-014 gnt  out  2  one-hot grant to a DMA master.
REQ-015 owner  out  1  index of the granted master; valid while gnt is non-zero.
REQ-016 preempt  out  1  one-clk pulse when a tenure ends on MAXBURST.

Function
REQ-017 The FSM SHALL have five states: IDLE, REQ, SYNC, OWN, REL.
REQ-018 IDLE: when req is non-zero, register the winner, drive BRn=0 and go to REQ.
REQ-019 Winner: a single request wins directly; if both request, the master not granted last time wins (round-robin); after reset, bit0 wins.
REQ-020 REQ: when BGn=0, go to SYNC.
REQ-021 REQ: if the winner's req drops before BGn=0, drive BRn=1 and return to IDLE.
REQ-022 SYNC: wait until ASn=1 and bus_busy=0 have both held for GNTDLY cpu_cen ticks, then drive BGACKn=0 on the next clk and go to OWN.
REQ-023 BRn SHALL return to 1 on the same clk edge that BGACKn goes to 0.
REQ-024 OWN: assert gnt for the winner only; each strobe pulse from the owner increments an 8-bit burst counter.
REQ-025 OWN exits to REL on any of: owner strobe with last=1; owner req deasserting; burst counter reaching MAXBURST (this case also pulses preempt).
REQ-026 Strobes from the non-owner SHALL be ignored.
REQ-027 REL: gnt=0 and BGACKn=1 for exactly one clk; the burst counter clears; the last-granted record updates; then go to IDLE.
REQ-028 A requester still active after REL SHALL re-arbitrate from IDLE, so the CPU gets at least one bus opportunity between tenures.
REQ-029 gnt SHALL be non-zero only in OWN, and at most one gnt bit may be set at a time.
REQ-030 BGACKn=0 SHALL occur only in OWN; BRn=0 only in REQ and SYNC.
REQ-031 gnt, BGACKn and BRn SHALL be registered outputs with no combinational path from inputs.
REQ-032 A strobe coinciding with the REL transition SHALL NOT count toward the next tenure.

Reset
REQ-033 While rstn=0 the FSM is in IDLE, BRn=1, BGACKn=1, gnt=0, owner=0, preempt=0, the burst counter is 0 and last-granted points at bit1.
REQ-034 If rstn is asserted mid-tenure, all outputs SHALL take their reset values immediately (asynchronously), with no REL cycle.

Structure
REQ-035 The state encoding and the MAXBURST/GNTDLY defaults SHALL live in the shared package jtriders_pkg.
REQ-036 The two-input round-robin selector SHALL be one sub-module, jtriders_rrsel.
REQ-037 The block SHALL be instantiated between jtriders_prot, the object DMA and jtframe_m68k, replacing the direct BRn/BGACKn wiring.

Verification
REQ-038 Scenario: req=01, BGn falls 3 clk later, ASn=1, bus_busy=0 -> BGACKn=0 after GNTDLY cpu_cen ticks, BRn=1 on that same edge, gnt=01.
REQ-039 Scenario: req=11 from IDLE after reset -> gnt=01 first; after master 0 sends last=1, REL lasts 1 clk, then the next tenure gives gnt=10.
REQ-040 Scenario: req=10 held, 64 owner strobes with last=0 -> preempt pulses, REL, then re-request with BRn=0 again.
REQ-041 Scenario: req=01 drops while in REQ -> BRn=1 next clk, FSM returns to IDLE, BGACKn stays 1.
REQ-042 Scenario: in SYNC with bus_busy=1 held for 10 cpu_cen ticks -> BGACKn stays 1 until bus_busy=0 plus GNTDLY ticks.
REQ-043 Scenario: rstn=0 pulse while in OWN -> BGACKn=1, gnt=0, BRn=1 with no clk edge needed; counter reads 0 after release.
